// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation station: entry layout,
// command-bundle bit positions and the "operand ready" tag value.
package rs_pkg;

  localparam int ROB_SIZE = 32;
  localparam int TAG_W    = $clog2(ROB_SIZE + 1);
  localparam int CMD_W    = 10;
  localparam int DATA_W   = 64;

  typedef logic [TAG_W-1:0] tag_t;

  // Tag 0 means "no producer": the operand value is already valid.
  localparam tag_t TAG_READY = '0;

  localparam int CMD_MEMWRITE = 0;
  localparam int CMD_MEMTOREG = 1;
  localparam int CMD_ALUOP_LO = 2;
  localparam int CMD_ALUOP_HI = 4;
  localparam int CMD_REGWRITE = 5;
  localparam int CMD_FWD      = 6;
  localparam int CMD_LSL      = 7;
  localparam int CMD_SAVECOND = 8;
  localparam int CMD_RDEN     = 9;

  typedef struct packed {
    logic              valid;
    tag_t              dest_tag;
    tag_t              tag1;
    tag_t              tag2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [CMD_W-1:0]  cmd;
  } rs_entry_t;

  // A broadcast on the CDB never matches the ready tag.
  function automatic logic cdb_match(input logic cdb_valid, input tag_t cdb_tag,
                                     input tag_t op_tag);
    return cdb_valid && (cdb_tag != TAG_READY) && (cdb_tag == op_tag);
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, CDB and issue signals of one reservation station; master is the
// decode/CDB/execution side, slave is the reservation station itself.
interface reservation_station_if #(
  parameter int ROBsizeLog = 6,
  parameter int CMDwidth   = 10
);
  logic                  flush_i;
  logic                  writeEn_i;
  logic [ROBsizeLog-1:0] robTag_i;
  logic [ROBsizeLog-1:0] robTag1_i;
  logic [ROBsizeLog-1:0] robTag2_i;
  logic [64:0]           robVal1_i;
  logic [64:0]           robVal2_i;
  logic [CMDwidth-1:0]   commands_i;
  logic                  stall_o;
  logic                  cdbValid_i;
  logic [ROBsizeLog-1:0] cdbTag_i;
  logic [63:0]           cdbData_i;
  logic                  issueValid_o;
  logic                  issueReady_i;
  logic [ROBsizeLog-1:0] issueTag_o;
  logic [63:0]           issueOp1_o;
  logic [63:0]           issueOp2_o;
  logic [CMDwidth-1:0]   issueCommands_o;

  modport master (
    output flush_i, writeEn_i, robTag_i, robTag1_i, robTag2_i, robVal1_i,
           robVal2_i, commands_i, cdbValid_i, cdbTag_i, cdbData_i, issueReady_i,
    input  stall_o, issueValid_o, issueTag_o, issueOp1_o, issueOp2_o,
           issueCommands_o
  );

  modport slave (
    input  flush_i, writeEn_i, robTag_i, robTag1_i, robTag2_i, robVal1_i,
           robVal2_i, commands_i, cdbValid_i, cdbTag_i, cdbData_i, issueReady_i,
    output stall_o, issueValid_o, issueTag_o, issueOp1_o, issueOp2_o,
           issueCommands_o
  );
endinterface

// File: rtl/rs_select.sv
// Combinational oldest-ready picker: grants the ready entry that no other
// ready entry is older than.
module rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] older,
  output logic [N-1:0]        grant,
  output logic                any_ready
);

  logic [N-1:0] blocked;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j != i && ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = ready & ~blocked;
  end

  assign any_ready = |ready;

endmodule

// File: rtl/reservation_station.sv
// Operand buffer for one functional unit: holds dispatched ops until both
// operands resolve via the CDB, then issues the oldest ready op.
module reservation_station
  import rs_pkg::*;
#(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RSentries  = 4,
  parameter int CMDwidth   = 10
) (
  input logic                  clk_i,
  input logic                  reset_i,
  reservation_station_if.slave bus
);

  localparam int IDX_W = $clog2(RSentries);

  rs_entry_t                               entry_q [RSentries];
  logic [RSentries-1:0][RSentries-1:0]     older_q;
  logic                                    issue_valid_q;
  logic [ROBsizeLog-1:0]                   issue_tag_q;
  logic [63:0]                             issue_op1_q;
  logic [63:0]                             issue_op2_q;
  logic [CMDwidth-1:0]                     issue_cmd_q;

  logic [RSentries-1:0] valid_vec;
  logic [RSentries-1:0] ready_vec;
  logic [RSentries-1:0] wake1;
  logic [RSentries-1:0] wake2;
  logic [RSentries-1:0] grant;
  logic [RSentries-1:0] freed;
  logic                 any_ready;
  logic                 stall;
  logic                 dispatch_en;
  logic                 load_en;
  logic                 issue_fire;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     sel_idx;
  rs_entry_t            new_entry;
  logic                 unused_val_msbs;

  assign unused_val_msbs = bus.robVal1_i[64] ^ bus.robVal2_i[64];

  always_comb begin
    for (int i = 0; i < RSentries; i++) begin
      valid_vec[i] = entry_q[i].valid;
      ready_vec[i] = entry_q[i].valid && entry_q[i].tag1 == TAG_READY
                     && entry_q[i].tag2 == TAG_READY;
      wake1[i]     = entry_q[i].valid
                     && cdb_match(bus.cdbValid_i, bus.cdbTag_i, entry_q[i].tag1);
      wake2[i]     = entry_q[i].valid
                     && cdb_match(bus.cdbValid_i, bus.cdbTag_i, entry_q[i].tag2);
    end
  end

  // Stall depends only on registered occupancy so decode never sees a loop.
  assign stall       = &valid_vec;
  assign dispatch_en = bus.writeEn_i && !stall && !bus.flush_i;
  assign load_en     = !issue_valid_q || bus.issueReady_i;
  assign issue_fire  = load_en && any_ready;
  assign freed       = issue_fire ? grant : '0;

  always_comb begin
    free_idx = '0;
    for (int i = RSentries - 1; i >= 0; i--) begin
      if (!valid_vec[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < RSentries; i++) begin
      if (grant[i]) sel_idx = IDX_W'(i);
    end
  end

  // An operand produced on the CDB in the dispatch cycle is captured directly.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.dest_tag = bus.robTag_i;
    new_entry.cmd      = bus.commands_i;
    if (cdb_match(bus.cdbValid_i, bus.cdbTag_i, bus.robTag1_i)) begin
      new_entry.tag1 = TAG_READY;
      new_entry.val1 = bus.cdbData_i;
    end else begin
      new_entry.tag1 = bus.robTag1_i;
      new_entry.val1 = bus.robVal1_i[63:0];
    end
    if (cdb_match(bus.cdbValid_i, bus.cdbTag_i, bus.robTag2_i)) begin
      new_entry.tag2 = TAG_READY;
      new_entry.val2 = bus.cdbData_i;
    end else begin
      new_entry.tag2 = bus.robTag2_i;
      new_entry.val2 = bus.robVal2_i[63:0];
    end
  end

  rs_select #(.N(RSentries)) u_select (
    .ready     (ready_vec),
    .older     (older_q),
    .grant     (grant),
    .any_ready (any_ready)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < RSentries; i++) entry_q[i] <= '0;
    end else if (bus.flush_i) begin
      for (int i = 0; i < RSentries; i++) entry_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < RSentries; i++) begin
        if (dispatch_en && free_idx == IDX_W'(i)) begin
          entry_q[i] <= new_entry;
        end else begin
          if (freed[i]) entry_q[i].valid <= 1'b0;
          if (wake1[i]) begin
            entry_q[i].val1 <= bus.cdbData_i;
            entry_q[i].tag1 <= TAG_READY;
          end
          if (wake2[i]) begin
            entry_q[i].val2 <= bus.cdbData_i;
            entry_q[i].tag2 <= TAG_READY;
          end
        end
      end
    end
  end

  // New entry is younger than every surviving entry and older than none.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      older_q <= '0;
    end else if (bus.flush_i) begin
      older_q <= '0;
    end else if (dispatch_en) begin
      for (int i = 0; i < RSentries; i++) begin
        for (int j = 0; j < RSentries; j++) begin
          if (free_idx == IDX_W'(i)) begin
            older_q[i][j] <= 1'b0;
          end else if (free_idx == IDX_W'(j)) begin
            older_q[i][j] <= valid_vec[i] && !freed[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      issue_valid_q <= 1'b0;
      issue_tag_q   <= '0;
      issue_op1_q   <= '0;
      issue_op2_q   <= '0;
      issue_cmd_q   <= '0;
    end else if (bus.flush_i) begin
      issue_valid_q <= 1'b0;
    end else if (load_en) begin
      issue_valid_q <= any_ready;
      if (any_ready) begin
        issue_tag_q <= entry_q[sel_idx].dest_tag;
        issue_op1_q <= entry_q[sel_idx].val1;
        issue_op2_q <= entry_q[sel_idx].val2;
        issue_cmd_q <= entry_q[sel_idx].cmd;
      end
    end
  end

  assign bus.stall_o         = stall;
  assign bus.issueValid_o    = issue_valid_q;
  assign bus.issueTag_o      = issue_tag_q;
  assign bus.issueOp1_o      = issue_op1_q;
  assign bus.issueOp2_o      = issue_op2_q;
  assign bus.issueCommands_o = issue_cmd_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wakeup, bypass, stall,
// age ordering under backpressure and flush.
module tb_reservation_station;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  reservation_station_if #(.ROBsizeLog(6), .CMDwidth(10)) bus ();

  reservation_station dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_i      = 1'b0;
    bus.writeEn_i    = 1'b0;
    bus.robTag_i     = '0;
    bus.robTag1_i    = '0;
    bus.robTag2_i    = '0;
    bus.robVal1_i    = '0;
    bus.robVal2_i    = '0;
    bus.commands_i   = '0;
    bus.cdbValid_i   = 1'b0;
    bus.cdbTag_i     = '0;
    bus.cdbData_i    = '0;
    bus.issueReady_i = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_dispatch(input logic [5:0] tag, input logic [5:0] t1,
                              input logic [5:0] t2, input logic [64:0] v1,
                              input logic [64:0] v2, input logic [9:0] cmd);
    bus.writeEn_i  = 1'b1;
    bus.robTag_i   = tag;
    bus.robTag1_i  = t1;
    bus.robTag2_i  = t2;
    bus.robVal1_i  = v1;
    bus.robVal2_i  = v2;
    bus.commands_i = cmd;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.writeEn_i = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.issueValid_o); end
    tests_run++;
    if (bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
    tests_run++;
    if ({bus.issueTag_o, bus.issueOp1_o, bus.issueOp2_o, bus.issueCommands_o} !== '0) begin
      tests_failed++; $display("FAIL reset_data: tag %h op1 %h op2 %h cmd %h want all 0",
                               bus.issueTag_o, bus.issueOp1_o, bus.issueOp2_o, bus.issueCommands_o);
    end
    bus.writeEn_i = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_ready_dispatch();
    do_reset();
    set_dispatch(6'd1, 6'd0, 6'd0, 65'h1_0000_0000_0000_0005, 65'h0_0000_0000_0000_0007, 10'h2A5);
    tick();
    idle_inputs();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL rdy_early: valid %b want 0", bus.issueValid_o); end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b1 || bus.issueTag_o !== 6'd1) begin
      tests_failed++; $display("FAIL rdy_issue: valid %b tag %0d want 1/1", bus.issueValid_o, bus.issueTag_o);
    end
    tests_run++;
    if (bus.issueOp1_o !== 64'd5 || bus.issueOp2_o !== 64'd7 || bus.issueCommands_o !== 10'h2A5) begin
      tests_failed++; $display("FAIL rdy_ops: op1 %h op2 %h cmd %h want 5/7/2a5",
                               bus.issueOp1_o, bus.issueOp2_o, bus.issueCommands_o);
    end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL rdy_drain: valid %b want 0", bus.issueValid_o); end
  endtask

  task automatic test_wakeup();
    do_reset();
    set_dispatch(6'd2, 6'd3, 6'd0, 65'd0, 65'd9, 10'h001);
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL wake_pending: valid %b want 0", bus.issueValid_o); end
    bus.cdbValid_i = 1'b1;
    bus.cdbTag_i   = 6'd3;
    bus.cdbData_i  = 64'hAA;
    tick();
    idle_inputs();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL wake_same: valid %b want 0", bus.issueValid_o); end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b1 || bus.issueTag_o !== 6'd2 || bus.issueOp1_o !== 64'hAA
        || bus.issueOp2_o !== 64'd9) begin
      tests_failed++; $display("FAIL wake_issue: valid %b tag %0d op1 %h op2 %h want 1/2/aa/9",
                               bus.issueValid_o, bus.issueTag_o, bus.issueOp1_o, bus.issueOp2_o);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    set_dispatch(6'd5, 6'd0, 6'd4, 65'd1, 65'd0, 10'h010);
    bus.cdbValid_i = 1'b1;
    bus.cdbTag_i   = 6'd4;
    bus.cdbData_i  = 64'h55;
    tick();
    idle_inputs();
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b1 || bus.issueTag_o !== 6'd5 || bus.issueOp2_o !== 64'h55
        || bus.issueOp1_o !== 64'd1) begin
      tests_failed++; $display("FAIL bypass: valid %b tag %0d op1 %h op2 %h want 1/5/1/55",
                               bus.issueValid_o, bus.issueTag_o, bus.issueOp1_o, bus.issueOp2_o);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_dispatch(6'(20 + k), 6'(10 + k), 6'd0, 65'd0, 65'd0, 10'(k));
      tick();
    end
    idle_inputs();
    tests_run++;
    if (bus.stall_o !== 1'b1) begin tests_failed++; $display("FAIL full_stall: got %b want 1", bus.stall_o); end
    set_dispatch(6'd30, 6'd0, 6'd0, 65'd3, 65'd4, 10'h3FF);
    tick();
    idle_inputs();
    tests_run++;
    if (bus.stall_o !== 1'b1) begin tests_failed++; $display("FAIL full_hold: got %b want 1", bus.stall_o); end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL full_reject: valid %b tag %0d want 0", bus.issueValid_o, bus.issueTag_o); end
    bus.cdbValid_i = 1'b1;
    bus.cdbTag_i   = 6'd12;
    bus.cdbData_i  = 64'h77;
    tick();
    idle_inputs();
    tests_run++;
    if (bus.stall_o !== 1'b1 || bus.issueValid_o !== 1'b0) begin
      tests_failed++; $display("FAIL full_woken: stall %b valid %b want 1/0", bus.stall_o, bus.issueValid_o);
    end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b1 || bus.issueTag_o !== 6'd22 || bus.issueOp1_o !== 64'h77) begin
      tests_failed++; $display("FAIL full_issue: valid %b tag %0d op1 %h want 1/22/77",
                               bus.issueValid_o, bus.issueTag_o, bus.issueOp1_o);
    end
    tests_run++;
    if (bus.stall_o !== 1'b0) begin tests_failed++; $display("FAIL full_release: stall %b want 0", bus.stall_o); end
  endtask

  task automatic test_age_hold();
    do_reset();
    set_dispatch(6'd6, 6'd0, 6'd0, 65'd1, 65'd1, 10'd0);
    tick();
    set_dispatch(6'd7, 6'd9, 6'd0, 65'd0, 65'd2, 10'd0);
    tick();
    set_dispatch(6'd8, 6'd9, 6'd0, 65'd0, 65'd3, 10'd0);
    tick();
    idle_inputs();
    bus.issueReady_i = 1'b0;
    bus.cdbValid_i   = 1'b1;
    bus.cdbTag_i     = 6'd9;
    bus.cdbData_i    = 64'h99;
    tick();
    bus.cdbValid_i = 1'b0;
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL age_woken: valid %b want 0", bus.issueValid_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.cdbValid_i = (c == 0);
      bus.cdbData_i  = 64'h1234;
      tests_run++;
      if (bus.issueValid_o !== 1'b1 || bus.issueTag_o !== 6'd7 || bus.issueOp1_o !== 64'h99
          || bus.issueOp2_o !== 64'd2) begin
        tests_failed++; $display("FAIL age_hold_%0d: valid %b tag %0d op1 %h op2 %h want 1/7/99/2",
                                 c, bus.issueValid_o, bus.issueTag_o, bus.issueOp1_o, bus.issueOp2_o);
      end
    end
    bus.cdbValid_i   = 1'b0;
    bus.issueReady_i = 1'b1;
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b1 || bus.issueTag_o !== 6'd8 || bus.issueOp2_o !== 64'd3) begin
      tests_failed++; $display("FAIL age_second: valid %b tag %0d op2 %h want 1/8/3",
                               bus.issueValid_o, bus.issueTag_o, bus.issueOp2_o);
    end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL age_drain: valid %b want 0", bus.issueValid_o); end
  endtask

  task automatic test_flush();
    do_reset();
    bus.issueReady_i = 1'b0;
    set_dispatch(6'd1, 6'd0, 6'd0, 65'd1, 65'd1, 10'd0);
    tick();
    set_dispatch(6'd2, 6'd11, 6'd0, 65'd0, 65'd0, 10'd0);
    tick();
    set_dispatch(6'd3, 6'd12, 6'd0, 65'd0, 65'd0, 10'd0);
    tick();
    set_dispatch(6'd4, 6'd13, 6'd0, 65'd0, 65'd0, 10'd0);
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b1 || bus.stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_pre: valid %b stall %b want 1/0", bus.issueValid_o, bus.stall_o);
    end
    set_dispatch(6'd30, 6'd0, 6'd0, 65'd5, 65'd5, 10'd0);
    bus.flush_i = 1'b1;
    tick();
    idle_inputs();
    tests_run++;
    if (bus.issueValid_o !== 1'b0 || bus.stall_o !== 1'b0) begin
      tests_failed++; $display("FAIL flush_clear: valid %b stall %b want 0/0", bus.issueValid_o, bus.stall_o);
    end
    bus.cdbValid_i = 1'b1;
    bus.cdbTag_i   = 6'd11;
    bus.cdbData_i  = 64'hBEEF;
    tick();
    bus.cdbValid_i = 1'b0;
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_drop: valid %b tag %0d want 0", bus.issueValid_o, bus.issueTag_o); end
    tick();
    tests_run++;
    if (bus.issueValid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_cdb: valid %b tag %0d want 0", bus.issueValid_o, bus.issueTag_o); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    idle_inputs();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_full_stall();
    test_age_hold();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
